// File: rtl/uart_pkg.sv
// Shared UART definitions: the state encoding used by RX and TX, oversampling constants
// and the legal stop-bit tick counts.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_TICK    = 7;
  localparam int unsigned S_CNT_W     = 5;

  localparam int unsigned SB_TICK_1   = 16;
  localparam int unsigned SB_TICK_1P5 = 24;
  localparam int unsigned SB_TICK_2   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; RST_VAL sets the reset level.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_ff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ff <= {2{RST_VAL}};
    end else begin
      r_ff <= {r_ff[0], i_async};
    end
  end

  assign o_sync = r_ff[1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver with 16x oversampling; one rx_done_tick per frame with data and error flags.
// Optional parity state and ports are built in when UART_RX_PARITY_EN is defined.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = SB_TICK_1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
`ifdef UART_RX_PARITY_EN
  input  logic            parity_odd,
  output logic            parity_err,
`endif
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done_tick,
  output logic            rx_busy,
  output logic            frame_err
);

  localparam int unsigned N_CNT_W = 3;
  localparam logic [S_CNT_W-1:0] S_MID  = S_CNT_W'(MID_TICK);
  localparam logic [S_CNT_W-1:0] S_LAST = S_CNT_W'(OVERSAMPLE - 1);
  localparam logic [S_CNT_W-1:0] S_STOP = S_CNT_W'(SB_TICK - 1);
  localparam logic [N_CNT_W-1:0] N_LAST = N_CNT_W'(DBIT - 1);

  uart_state_e          r_state;
  logic [S_CNT_W-1:0]   r_s_cnt;
  logic [N_CNT_W-1:0]   r_n_cnt;
  logic [DBIT-1:0]      r_shift;
  logic [DBIT-1:0]      r_rx_data;
  logic                 r_done;
  logic                 r_busy;
  logic                 r_ferr;
  logic                 w_rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_perr;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // Frame sequencer; busy is updated on every transition so it mirrors state != IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_s_cnt   <= '0;
      r_n_cnt   <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_s_cnt <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_s_cnt == S_MID) begin
              r_s_cnt <= '0;
              if (!w_rx_s) begin
                r_state <= ST_DATA;
                r_n_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_s_cnt <= r_s_cnt + S_CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_s_cnt == S_LAST) begin
              r_s_cnt <= '0;
              r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
              if (r_n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_n_cnt <= r_n_cnt + N_CNT_W'(1);
              end
            end else begin
              r_s_cnt <= r_s_cnt + S_CNT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (r_s_cnt == S_LAST) begin
              r_s_cnt   <= '0;
              r_par_bit <= w_rx_s;
              r_state   <= ST_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + S_CNT_W'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (r_s_cnt == S_STOP) begin
              r_s_cnt   <= '0;
              r_rx_data <= r_shift;
              r_done    <= 1'b1;
              r_ferr    <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
              r_perr    <= (^r_shift) ^ r_par_bit ^ parity_odd;
`endif
              if (w_rx_s) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_BREAK;
              end
            end else begin
              r_s_cnt <= r_s_cnt + S_CNT_W'(1);
            end
          end
        end
        // Held-low line: wait for the line to recover instead of framing garbage.
        ST_BREAK: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_done_tick = r_done;
  assign rx_busy      = r_busy;
  assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus random bytes against a frame-level model.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       rx_busy;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] obs_data[$];
  bit         obs_ferr[$];
  bit         obs_perr[$];
  int         done_cnt = 0;
  int         wide_cnt = 0;
  bit         prev_done = 1'b0;

  uart_rx_core #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
`ifdef UART_RX_PARITY_EN
    .parity_odd   (parity_odd),
    .parity_err   (parity_err),
`endif
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .rx_busy      (rx_busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Capture every completed frame as seen by the host.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      obs_data.push_back(rx_data);
      obs_ferr.push_back(frame_err);
`ifdef UART_RX_PARITY_EN
      obs_perr.push_back(parity_err);
`else
      obs_perr.push_back(1'b0);
`endif
      if (prev_done) wide_cnt++;
    end
    prev_done = rx_done_tick;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_val);
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      hold(BIT_CLKS);
    end
    if (PAR_EN) begin
      rx = par_bit;
      hold(BIT_CLKS);
    end
    rx = stop_val;
    hold(BIT_CLKS);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    hold(5);
    reset_n = 1'b1;
    hold(4);
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
`ifdef UART_RX_PARITY_EN
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
`endif
  endtask

  task automatic test_basic();
    int base = done_cnt;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    hold(16);
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", done_cnt - base); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", rx_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b exp=0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%b exp=0", rx_busy); end
    checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL basic_pulse_width wide=%0d exp=0", wide_cnt); end
  endtask

  task automatic test_glitch();
    int         base = done_cnt;
    logic [7:0] prev_data = rx_data;
    logic       prev_ferr = frame_err;
    rx = 1'b0;
    hold(20);
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b exp=1", rx_busy); end
    rx = 1'b1;
    hold(80);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_low got=%b exp=0", rx_busy); end
    checks++; if (done_cnt - base !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", done_cnt - base); end
    checks++; if (rx_data !== prev_data) begin failures++; $display("FAIL glitch_data got=%h exp=%h", rx_data, prev_data); end
    checks++; if (frame_err !== prev_ferr) begin failures++; $display("FAIL glitch_ferr got=%b exp=%b", frame_err, prev_ferr); end
  endtask

  task automatic test_break();
    int base = done_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    hold(40 * 4);
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL break_pulses got=%0d exp=1", done_cnt - base); end
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL break_data got=%h exp=3c", rx_data); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL break_ferr got=%b exp=1", frame_err); end
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL break_busy_held got=%b exp=1", rx_busy); end
    rx = 1'b1;
    hold(8);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL break_busy_release got=%b exp=0", rx_busy); end
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL break_second_pulse got=%0d exp=1", done_cnt - base); end
    hold(BIT_CLKS);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int base = done_cnt;
    exp_q = '{8'h00, 8'hFF, 8'h81};
    foreach (exp_q[k]) send_frame(exp_q[k], ^exp_q[k], 1'b1);
    hold(16);
    checks++; if (done_cnt - base !== 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", done_cnt - base); end
    foreach (exp_q[k]) begin
      logic [7:0] got = (base + k < obs_data.size()) ? obs_data[base + k] : 8'hxx;
      bit         fe  = (base + k < obs_ferr.size()) ? obs_ferr[base + k] : 1'b1;
      checks++; if (got !== exp_q[k]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, got, exp_q[k]); end
      checks++; if (fe !== 1'b0) begin failures++; $display("FAIL b2b_ferr[%0d] got=%b exp=0", k, fe); end
    end
    checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL b2b_pulse_width wide=%0d exp=0", wide_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int base = done_cnt;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] d = 8'($urandom);
      exp_q.push_back(d);
      send_frame(d, ^d, 1'b1);
      hold(int'($urandom_range(0, 40)));
    end
    hold(16);
    checks++; if (done_cnt - base !== 8) begin failures++; $display("FAIL rand_pulses got=%0d exp=8", done_cnt - base); end
    foreach (exp_q[k]) begin
      logic [7:0] got = (base + k < obs_data.size()) ? obs_data[base + k] : 8'hxx;
      checks++; if (got !== exp_q[k]) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", k, got, exp_q[k]); end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [7:0] d = 8'hC3;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      hold(BIT_CLKS);
    end
    rx = d[4];
    hold(BIT_CLKS / 2);
    base = done_cnt;
    reset_n = 1'b0;
    rx      = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_done_tick !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_ferr got=%b exp=0", frame_err); end
    hold(3);
    reset_n = 1'b1;
    hold(6 * BIT_CLKS);
    checks++; if (done_cnt - base !== 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=0", done_cnt - base); end
    send_frame(8'h5A, ^8'h5A, 1'b1);
    hold(16);
    checks++; if (done_cnt - base !== 1) begin failures++; $display("FAIL midrst_next_pulses got=%0d exp=1", done_cnt - base); end
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL midrst_next_data got=%h exp=5a", rx_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_next_ferr got=%b exp=0", frame_err); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base = done_cnt;
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    hold(16);
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_even_ok got=%b exp=0", parity_err); end
    send_frame(8'h07, 1'b0, 1'b1);
    hold(16);
    checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_even_bad got=%b exp=1", parity_err); end
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    hold(16);
    checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_odd_ok got=%b exp=0", parity_err); end
    checks++; if (done_cnt - base !== 3) begin failures++; $display("FAIL par_pulses got=%0d exp=3", done_cnt - base); end
    parity_odd = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_random();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
